// File: rtl/call_register.sv
// Elevator call register: synchronizes raw buttons, latches presses,
// clears on serve, and summarizes pending requests relative to the cabin.
module call_register (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] floor_in,
    input  logic [7:0] up_in,
    input  logic [7:0] down_in,
    input  logic [2:0] floor,
    input  logic [1:0] dir,
    input  logic       serve,
    output logic [7:0] floor_btn,
    output logic [7:0] up,
    output logic [7:0] down,
    output logic       req_above,
    output logic       req_below,
    output logic       req_here
);

    localparam int CAB = 0;
    localparam int UPC = 1;
    localparam int DNC = 2;

    logic [2:0][7:0] raw;
    logic [2:0][7:0] s1_q;
    logic [2:0][7:0] s2_q;
    logic [2:0][7:0] prev_q;
    logic [2:0][7:0] press;

    logic [7:0] cab_q, cab_d;
    logic [7:0] up_q,  up_d;
    logic [7:0] dn_q,  dn_d;

    logic [7:0] here_oh;
    logic [7:0] clr_cab;
    logic [7:0] clr_up;
    logic [7:0] clr_dn;
    logic [7:0] any_req;
    logic [7:0] above_mask;
    logic [7:0] below_mask;

    assign raw = {down_in, up_in, floor_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            cab_q  <= '0;
            up_q   <= '0;
            dn_q   <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cab_q  <= cab_d;
            up_q   <= up_d;
            dn_q   <= dn_d;
        end
    end

    // Press = rising edge of the synchronized value; clear beats set.
    always_comb begin
        press   = s2_q & ~prev_q;
        here_oh = 8'b1 << floor;
        clr_cab = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (serve) begin
            clr_cab = here_oh;
            if (dir != 2'b10) clr_up = here_oh;
            if (dir != 2'b01) clr_dn = here_oh;
        end
        cab_d = (cab_q | press[CAB]) & ~clr_cab;
        up_d  = (up_q  | press[UPC]) & ~clr_up & 8'h7F;
        dn_d  = (dn_q  | press[DNC]) & ~clr_dn & 8'hFE;
    end

    always_comb begin
        any_req    = cab_q | up_q | dn_q;
        above_mask = 8'hFE << floor;
        below_mask = here_oh - 8'd1;
        req_above  = |(any_req & above_mask);
        req_below  = |(any_req & below_mask);
        req_here   = |(any_req & here_oh);
    end

    assign floor_btn = cab_q;
    assign up        = up_q;
    assign down      = dn_q;

endmodule
